// File: rtl/nes_mem_arbiter_if.sv
// Bus bundle for nes_mem_arbiter: requester strobes/results plus the memory port.
// Requests are one-cycle strobes sampled on the rising clock edge. There is no ready
// back-pressure: a strobe aimed at an occupied slot is dropped and flagged by overrun.
// Each *_valid / ld_ack output is a single-cycle pulse.
interface nes_mem_arbiter_if #(
  parameter int ADDR_W = 22
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_d;
  logic [7:0]        cpu_q;
  logic              cpu_valid;
  logic              ppu_rd;
  logic [ADDR_W-1:0] ppu_addr;
  logic [7:0]        ppu_q;
  logic              ppu_valid;
  logic              ld_wr;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_d;
  logic              ld_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [7:0]        mem_d;
  logic [7:0]        mem_q;
  logic              overrun;
  logic [1:0]        dbg_state;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_d, ppu_rd, ppu_addr,
           ld_wr, ld_addr, ld_d, mem_q,
    output cpu_q, cpu_valid, ppu_q, ppu_valid, ld_ack,
           mem_addr, mem_re, mem_we, mem_d, overrun, dbg_state
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_d, ppu_rd, ppu_addr,
           ld_wr, ld_addr, ld_d, mem_q,
    input  cpu_q, cpu_valid, ppu_q, ppu_valid, ld_ack,
           mem_addr, mem_re, mem_we, mem_d, overrun, dbg_state
  );
endinterface

// File: rtl/nes_mem_arbiter.sv
// Single-port memory arbiter for NES CPU, PPU and flash loader with fixed read latency.
// Optional NES_MEM_ARB_RR_EN: alternate CPU/PPU on ties instead of fixed PPU > CPU > LD.
module nes_mem_arbiter #(
  parameter int ADDR_W = 22,
  parameter int RD_LAT = 2
) (
  input  logic                clock,
  input  logic                reset,
  nes_mem_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1
  } state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              rd_cap_q, rd_cap_d;
  logic              rd_own_q, rd_own_d;

  logic              cpu_v_q, cpu_v_d, cpu_wr_q, cpu_wr_d;
  logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
  logic [7:0]        cpu_dat_q, cpu_dat_d;
  logic              ppu_v_q, ppu_v_d;
  logic [ADDR_W-1:0] ppu_addr_q, ppu_addr_d;
  logic              ld_v_q, ld_v_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [7:0]        ld_dat_q, ld_dat_d;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d, ppu_rdata_q, ppu_rdata_d;
  logic              cpu_valid_q, cpu_valid_d, ppu_valid_q, ppu_valid_d;
  logic              ld_ack_q, ld_ack_d;
  logic              overrun_q, overrun_d;

  logic can_issue, gnt_cpu, gnt_ppu, gnt_ld, rd_grant, wr_grant;
  logic cpu_req, cpu_busy, ppu_busy, ld_busy;

  assign can_issue = (state_q == S_IDLE);

`ifdef NES_MEM_ARB_RR_EN
  // last_ppu_q: 1 when the PPU won the most recent CPU/PPU tie.
  logic last_ppu_q, last_ppu_d;
  assign gnt_ppu    = can_issue & ppu_v_q & ~(cpu_v_q & last_ppu_q);
  assign gnt_cpu    = can_issue & cpu_v_q & (~ppu_v_q | last_ppu_q);
  assign last_ppu_d = (can_issue & cpu_v_q & ppu_v_q) ? ~last_ppu_q : last_ppu_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) last_ppu_q <= 1'b0;
    else       last_ppu_q <= last_ppu_d;
  end
`else
  assign gnt_ppu = can_issue & ppu_v_q;
  assign gnt_cpu = can_issue & cpu_v_q & ~ppu_v_q;
`endif

  assign gnt_ld   = can_issue & ld_v_q & ~ppu_v_q & ~cpu_v_q;
  assign rd_grant = gnt_ppu | (gnt_cpu & ~cpu_wr_q);
  assign wr_grant = (gnt_cpu & cpu_wr_q) | gnt_ld;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      rd_cap_q <= 1'b0;
      rd_own_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_cap_q <= rd_cap_d;
      rd_own_q <= rd_own_d;
    end
  end

  // Next state: rd_cap_d marks the cycle in which mem_q carries the read data.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_cap_d = 1'b0;
    rd_own_d = rd_grant ? gnt_ppu : rd_own_q;
    case (state_q)
      S_IDLE: begin
        if (rd_grant) begin
          state_d = S_RD_WAIT;
          cnt_d   = LAT;
        end
      end
      S_RD_WAIT: begin
        cnt_d = 3'(cnt_q - 3'd1);
        if (cnt_q == 3'd1) begin
          state_d  = S_IDLE;
          rd_cap_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and pending slots
  always_comb begin
    mem_re_d    = rd_grant;
    mem_we_d    = wr_grant;
    ld_ack_d    = gnt_ld;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (gnt_ppu)      mem_addr_d = ppu_addr_q;
    else if (gnt_cpu) mem_addr_d = cpu_addr_q;
    else if (gnt_ld)  mem_addr_d = ld_addr_q;
    if (gnt_cpu & cpu_wr_q) mem_wdata_d = cpu_dat_q;
    else if (gnt_ld)        mem_wdata_d = ld_dat_q;

    cpu_valid_d = rd_cap_q & ~rd_own_q;
    ppu_valid_d = rd_cap_q & rd_own_q;
    cpu_rdata_d = cpu_valid_d ? bus.mem_q : cpu_rdata_q;
    ppu_rdata_d = ppu_valid_d ? bus.mem_q : ppu_rdata_q;

    cpu_req  = bus.cpu_rd | bus.cpu_wr;
    cpu_busy = cpu_v_q & ~gnt_cpu;
    ppu_busy = ppu_v_q & ~gnt_ppu;
    ld_busy  = ld_v_q & ~gnt_ld;

    cpu_v_d    = cpu_busy;
    cpu_wr_d   = cpu_wr_q;
    cpu_addr_d = cpu_addr_q;
    cpu_dat_d  = cpu_dat_q;
    if (cpu_req & ~cpu_busy) begin
      cpu_v_d    = 1'b1;
      cpu_wr_d   = bus.cpu_wr;
      cpu_addr_d = bus.cpu_addr;
      cpu_dat_d  = bus.cpu_d;
    end

    ppu_v_d    = ppu_busy;
    ppu_addr_d = ppu_addr_q;
    if (bus.ppu_rd & ~ppu_busy) begin
      ppu_v_d    = 1'b1;
      ppu_addr_d = bus.ppu_addr;
    end

    ld_v_d    = ld_busy;
    ld_addr_d = ld_addr_q;
    ld_dat_d  = ld_dat_q;
    if (bus.ld_wr & ~ld_busy) begin
      ld_v_d    = 1'b1;
      ld_addr_d = bus.ld_addr;
      ld_dat_d  = bus.ld_d;
    end

    // Simultaneous CPU read+write keeps the write and counts the read as dropped.
    overrun_d = overrun_q | (cpu_req & cpu_busy) | (bus.cpu_rd & bus.cpu_wr)
              | (bus.ppu_rd & ppu_busy) | (bus.ld_wr & ld_busy);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_v_q     <= 1'b0;
      cpu_wr_q    <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_dat_q   <= 8'h00;
      ppu_v_q     <= 1'b0;
      ppu_addr_q  <= '0;
      ld_v_q      <= 1'b0;
      ld_addr_q   <= '0;
      ld_dat_q    <= 8'h00;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
      cpu_rdata_q <= 8'h00;
      ppu_rdata_q <= 8'h00;
      cpu_valid_q <= 1'b0;
      ppu_valid_q <= 1'b0;
      ld_ack_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cpu_v_q     <= cpu_v_d;
      cpu_wr_q    <= cpu_wr_d;
      cpu_addr_q  <= cpu_addr_d;
      cpu_dat_q   <= cpu_dat_d;
      ppu_v_q     <= ppu_v_d;
      ppu_addr_q  <= ppu_addr_d;
      ld_v_q      <= ld_v_d;
      ld_addr_q   <= ld_addr_d;
      ld_dat_q    <= ld_dat_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ppu_rdata_q <= ppu_rdata_d;
      cpu_valid_q <= cpu_valid_d;
      ppu_valid_q <= ppu_valid_d;
      ld_ack_q    <= ld_ack_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.cpu_q     = cpu_rdata_q;
  assign bus.cpu_valid = cpu_valid_q;
  assign bus.ppu_q     = ppu_rdata_q;
  assign bus.ppu_valid = ppu_valid_q;
  assign bus.ld_ack    = ld_ack_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_d     = mem_wdata_q;
  assign bus.overrun   = overrun_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Directed bench for nes_mem_arbiter with a fixed-latency memory model (RD_LAT=2).
// Inputs are driven and outputs sampled on the falling edge.
module tb_nes_mem_arbiter;
  localparam int ADDR_W = 22;
  localparam int RD_LAT = 2;

  logic clock;
  logic reset;
  int   n_chk;
  int   n_fail;

  nes_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  nes_mem_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: data appears on mem_q RD_LAT cycles after the mem_re cycle.
  logic [7:0] mem_a [logic [ADDR_W-1:0]];
  logic [7:0] rd_pipe [0:RD_LAT-1];

  initial begin
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = 8'hEE;
    mem_a[22'h000123] = 8'hA5;
    mem_a[22'h002000] = 8'h11;
    mem_a[22'h008000] = 8'h22;
  end

  always @(posedge clock) begin
    if (bus.mem_re)
      rd_pipe[0] <= mem_a.exists(bus.mem_addr) ? mem_a[bus.mem_addr] : 8'h00;
    else
      rd_pipe[0] <= 8'hEE;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (bus.mem_we) mem_a[bus.mem_addr] = bus.mem_d;
  end

  assign bus.mem_q = rd_pipe[RD_LAT-1];

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_inputs();
    bus.cpu_rd   = 1'b0;
    bus.cpu_wr   = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_d    = 8'h00;
    bus.ppu_rd   = 1'b0;
    bus.ppu_addr = '0;
    bus.ld_wr    = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_d     = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    step(2);
    n_chk++;
    if ({bus.mem_re, bus.mem_we, bus.cpu_valid, bus.ppu_valid, bus.ld_ack, bus.overrun} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b exp=000000",
               {bus.mem_re, bus.mem_we, bus.cpu_valid, bus.ppu_valid, bus.ld_ack, bus.overrun});
    end
    n_chk++;
    if ({bus.mem_addr, bus.mem_d, bus.cpu_q, bus.ppu_q} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got addr=%h d=%h cq=%h pq=%h exp all 0",
               bus.mem_addr, bus.mem_d, bus.cpu_q, bus.ppu_q);
    end
    reset = 1'b0;
  endtask

  task automatic test_lone_cpu_read();
    bus.cpu_rd = 1'b1; bus.cpu_addr = 22'h000123;
    step(1);
    bus.cpu_rd = 1'b0;
    n_chk++;
    if (bus.mem_re !== 1'b0) begin n_fail++; $display("FAIL lone_early_re got=%b exp=0", bus.mem_re); end
    step(1);
    n_chk++;
    if (bus.mem_re !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 22'h000123) begin
      n_fail++;
      $display("FAIL lone_issue got re=%b we=%b addr=%h exp re=1 we=0 addr=000123", bus.mem_re, bus.mem_we, bus.mem_addr);
    end
    step(2);
    n_chk++;
    if (bus.cpu_valid !== 1'b0) begin n_fail++; $display("FAIL lone_valid_early got=%b exp=0", bus.cpu_valid); end
    step(1);
    n_chk++;
    if (bus.cpu_valid !== 1'b1 || bus.cpu_q !== 8'hA5) begin
      n_fail++;
      $display("FAIL lone_data got valid=%b q=%h exp valid=1 q=a5", bus.cpu_valid, bus.cpu_q);
    end
    step(1);
    n_chk++;
    if (bus.cpu_valid !== 1'b0 || bus.cpu_q !== 8'hA5) begin
      n_fail++;
      $display("FAIL lone_hold got valid=%b q=%h exp valid=0 q=a5", bus.cpu_valid, bus.cpu_q);
    end
  endtask

  task automatic test_reset_mid_read();
    int pulses;
    bus.cpu_rd = 1'b1; bus.cpu_addr = 22'h000123;
    step(1);
    bus.cpu_rd = 1'b0;
    step(1);
    n_chk++;
    if (bus.mem_re !== 1'b1) begin n_fail++; $display("FAIL midrst_issue got re=%b exp=1", bus.mem_re); end
    step(1);
    #1 reset = 1'b1;
    #1;
    n_chk++;
    if ({bus.mem_re, bus.mem_we, bus.cpu_valid, bus.ppu_valid, bus.ld_ack, bus.overrun} !== 6'b0 ||
        {bus.mem_addr, bus.mem_d, bus.cpu_q, bus.ppu_q} !== '0 || bus.dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_zero got re=%b addr=%h cq=%h pq=%h st=%0d exp all 0",
               bus.mem_re, bus.mem_addr, bus.cpu_q, bus.ppu_q, bus.dbg_state);
    end
    step(1);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (bus.cpu_valid === 1'b1 || bus.mem_re === 1'b1) pulses++;
    end
    n_chk++;
    if (pulses !== 0) begin n_fail++; $display("FAIL midrst_no_valid got=%0d exp=0", pulses); end
  endtask

`ifdef NES_MEM_ARB_RR_EN
  task automatic test_rr_collision();
    logic [ADDR_W-1:0] first_a, second_a;
    logic [1:0]        first_v, second_v;
    for (int r = 0; r < 2; r++) begin
      first_a  = (r == 0) ? 22'h002000 : 22'h008000;
      second_a = (r == 0) ? 22'h008000 : 22'h002000;
      first_v  = (r == 0) ? 2'b10 : 2'b01;
      second_v = (r == 0) ? 2'b01 : 2'b10;
      bus.ppu_rd = 1'b1; bus.ppu_addr = 22'h002000;
      bus.cpu_rd = 1'b1; bus.cpu_addr = 22'h008000;
      step(1);
      bus.ppu_rd = 1'b0; bus.cpu_rd = 1'b0;
      step(1);
      n_chk++;
      if (bus.mem_re !== 1'b1 || bus.mem_addr !== first_a) begin
        n_fail++; $display("FAIL rr%0d_first got re=%b addr=%h exp re=1 addr=%h", r, bus.mem_re, bus.mem_addr, first_a);
      end
      step(3);
      n_chk++;
      if ({bus.ppu_valid, bus.cpu_valid} !== first_v || bus.mem_re !== 1'b1 || bus.mem_addr !== second_a) begin
        n_fail++;
        $display("FAIL rr%0d_second got pv,cv=%b re=%b addr=%h exp %b 1 %h", r,
                 {bus.ppu_valid, bus.cpu_valid}, bus.mem_re, bus.mem_addr, first_v, second_a);
      end
      step(3);
      n_chk++;
      if ({bus.ppu_valid, bus.cpu_valid} !== second_v || bus.ppu_q !== 8'h11 || bus.cpu_q !== 8'h22) begin
        n_fail++;
        $display("FAIL rr%0d_data got pv,cv=%b pq=%h cq=%h exp %b 11 22", r,
                 {bus.ppu_valid, bus.cpu_valid}, bus.ppu_q, bus.cpu_q, second_v);
      end
      step(1);
    end
  endtask
`else
  task automatic test_fixed_collision();
    bus.ppu_rd = 1'b1; bus.ppu_addr = 22'h002000;
    bus.cpu_rd = 1'b1; bus.cpu_addr = 22'h008000;
    step(1);
    bus.ppu_rd = 1'b0; bus.cpu_rd = 1'b0;
    step(1);
    n_chk++;
    if (bus.mem_re !== 1'b1 || bus.mem_addr !== 22'h002000) begin
      n_fail++; $display("FAIL coll_ppu_issue got re=%b addr=%h exp re=1 addr=002000", bus.mem_re, bus.mem_addr);
    end
    step(1);
    n_chk++;
    if (bus.mem_re !== 1'b0) begin n_fail++; $display("FAIL coll_re_pulse got=%b exp=0", bus.mem_re); end
    step(2);
    n_chk++;
    if (bus.ppu_valid !== 1'b1 || bus.ppu_q !== 8'h11 || bus.cpu_valid !== 1'b0) begin
      n_fail++; $display("FAIL coll_ppu_data got pv=%b pq=%h cv=%b exp 1 11 0", bus.ppu_valid, bus.ppu_q, bus.cpu_valid);
    end
    n_chk++;
    if (bus.mem_re !== 1'b1 || bus.mem_addr !== 22'h008000) begin
      n_fail++; $display("FAIL coll_cpu_issue got re=%b addr=%h exp re=1 addr=008000", bus.mem_re, bus.mem_addr);
    end
    step(3);
    n_chk++;
    if (bus.cpu_valid !== 1'b1 || bus.cpu_q !== 8'h22 || bus.ppu_valid !== 1'b0 || bus.ppu_q !== 8'h11) begin
      n_fail++;
      $display("FAIL coll_cpu_data got cv=%b cq=%h pv=%b pq=%h exp 1 22 0 11", bus.cpu_valid, bus.cpu_q, bus.ppu_valid, bus.ppu_q);
    end
    step(1);
  endtask
`endif

  task automatic test_loader();
    bus.cpu_rd = 1'b1; bus.cpu_addr = 22'h000123;
    bus.ld_wr  = 1'b1; bus.ld_addr  = 22'h000010; bus.ld_d = 8'h3C;
    step(1);
    bus.cpu_rd = 1'b0; bus.ld_wr = 1'b0;
    step(1);
    n_chk++;
    if (bus.mem_re !== 1'b1 || bus.mem_addr !== 22'h000123 || bus.ld_ack !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_cpu_first got re=%b we=%b addr=%h ack=%b exp 1 0 000123 0", bus.mem_re, bus.mem_we, bus.mem_addr, bus.ld_ack);
    end
    step(2);
    n_chk++;
    if (bus.ld_ack !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_fail++; $display("FAIL ld_wait got ack=%b we=%b exp 0 0", bus.ld_ack, bus.mem_we);
    end
    step(1);
    n_chk++;
    if (bus.ld_ack !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_re !== 1'b0 ||
        bus.mem_addr !== 22'h000010 || bus.mem_d !== 8'h3C) begin
      n_fail++;
      $display("FAIL ld_issue got ack=%b we=%b re=%b addr=%h d=%h exp 1 1 0 000010 3c",
               bus.ld_ack, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_d);
    end
    n_chk++;
    if (bus.cpu_valid !== 1'b1 || bus.cpu_q !== 8'hA5) begin
      n_fail++; $display("FAIL ld_cpu_data got cv=%b cq=%h exp 1 a5", bus.cpu_valid, bus.cpu_q);
    end
    step(1);
    n_chk++;
    if (bus.ld_ack !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_d !== 8'h3C) begin
      n_fail++; $display("FAIL ld_after got ack=%b we=%b d=%h exp 0 0 3c", bus.ld_ack, bus.mem_we, bus.mem_d);
    end
  endtask

  task automatic test_overrun();
    int re_cnt;
    bus.ppu_rd = 1'b1; bus.ppu_addr = 22'h000010;
    step(1);
    bus.ppu_rd = 1'b0;
    step(1);
    bus.ppu_rd = 1'b1; bus.ppu_addr = 22'h002000;
    step(1);
    n_chk++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first_ok got=%b exp=0", bus.overrun); end
    bus.ppu_addr = 22'h008000;
    step(1);
    bus.ppu_rd = 1'b0;
    n_chk++;
    if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got=%b exp=1", bus.overrun); end
    step(1);
    n_chk++;
    if (bus.ppu_valid !== 1'b1 || bus.ppu_q !== 8'h3C || bus.mem_re !== 1'b1 || bus.mem_addr !== 22'h002000) begin
      n_fail++;
      $display("FAIL ovr_readback got pv=%b pq=%h re=%b addr=%h exp 1 3c 1 002000", bus.ppu_valid, bus.ppu_q, bus.mem_re, bus.mem_addr);
    end
    step(3);
    n_chk++;
    if (bus.ppu_valid !== 1'b1 || bus.ppu_q !== 8'h11) begin
      n_fail++; $display("FAIL ovr_kept got pv=%b pq=%h exp 1 11", bus.ppu_valid, bus.ppu_q);
    end
    re_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (bus.mem_re === 1'b1) re_cnt++;
    end
    n_chk++;
    if (re_cnt !== 0 || bus.overrun !== 1'b1) begin
      n_fail++; $display("FAIL ovr_dropped got re_cycles=%0d ovr=%b exp 0 1", re_cnt, bus.overrun);
    end

    reset = 1'b1;
    step(1);
    reset = 1'b0;
    n_chk++;
    if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got=%b exp=0", bus.overrun); end
    bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b1; bus.cpu_addr = 22'h000040; bus.cpu_d = 8'h77;
    step(1);
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    n_chk++;
    if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL rw_ovr got=%b exp=1", bus.overrun); end
    step(1);
    n_chk++;
    if (bus.mem_we !== 1'b1 || bus.mem_re !== 1'b0 || bus.mem_addr !== 22'h000040 || bus.mem_d !== 8'h77) begin
      n_fail++;
      $display("FAIL rw_write got we=%b re=%b addr=%h d=%h exp 1 0 000040 77", bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_d);
    end
    re_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (bus.mem_re === 1'b1 || bus.mem_we === 1'b1) re_cnt++;
    end
    n_chk++;
    if (re_cnt !== 0 || bus.overrun !== 1'b1) begin
      n_fail++; $display("FAIL rw_only_write got extra=%0d ovr=%b exp 0 1", re_cnt, bus.overrun);
    end
  endtask

  // Sequence and report
  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_lone_cpu_read();
    test_reset_mid_read();
`ifdef NES_MEM_ARB_RR_EN
    test_rr_collision();
`else
    test_fixed_collision();
`endif
    test_loader();
    test_overrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
